// File: rtl/ls193_pkg.sv
// Shared opcodes, state encodings and widths for the LS193 command sequencer.
package ls193_pkg;

  localparam int Q_W   = 4;
  localparam int TMR_W = 16;

  localparam logic [1:0] OP_CLEAR = 2'b00;
  localparam logic [1:0] OP_LOAD  = 2'b01;
  localparam logic [1:0] OP_UP    = 2'b10;
  localparam logic [1:0] OP_DOWN  = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLR_ASSERT,
    ST_LOAD_ASSERT,
    ST_PULSE,
    ST_SETTLE,
    ST_CHECK
  } state_e;

  typedef enum logic [1:0] {
    PG_IDLE,
    PG_LO,
    PG_HI
  } pg_phase_e;

endpackage

// File: rtl/ls193_pulse_gen.sv
// Purpose: generates N low/high pulses on the UP or DOWN counter pin, with rise/sample/done strobes.
// Latency: pin goes low the cycle after start; done strobes in the last high cycle of the final pulse.
// Backpressure: start is honoured only when idle; abort ends the run after the current high phase.
module ls193_pulse_gen
  import ls193_pkg::*;
#(
  parameter int PULSE_LO = 2,
  parameter int PULSE_HI = 2,
  parameter int N_W      = 16
) (
  input  logic           clk,
  input  logic           rst_bar,
  input  logic           start,
  input  logic           dir_down,
  input  logic [N_W-1:0] n,
  input  logic           abort,
  output logic           up,
  output logic           down,
  output logic           rise,
  output logic           sample,
  output logic           done
);

  pg_phase_e        phase, phase_n;
  logic [TMR_W-1:0] tmr, tmr_n;
  logic [N_W-1:0]   rem, rem_n;
  logic             dn_q, dn_n;
  logic             abort_q;
  logic             last_lo, last_hi;

  assign last_lo = (phase == PG_LO) && (tmr == '0);
  assign last_hi = (phase == PG_HI) && (tmr == '0);
  assign rise    = last_lo;
  assign sample  = last_lo;
  assign done    = last_hi && ((rem == '0) || abort || abort_q);

  always_comb begin
    phase_n = phase;
    tmr_n   = tmr;
    rem_n   = rem;
    dn_n    = dn_q;
    case (phase)
      PG_IDLE: begin
        if (start) begin
          phase_n = PG_LO;
          tmr_n   = TMR_W'(PULSE_LO - 1);
          rem_n   = n;
          dn_n    = dir_down;
        end
      end
      PG_LO: begin
        if (tmr == '0) begin
          phase_n = PG_HI;
          tmr_n   = TMR_W'(PULSE_HI - 1);
          rem_n   = rem - N_W'(1);
        end else begin
          tmr_n = tmr - TMR_W'(1);
        end
      end
      PG_HI: begin
        if (tmr == '0) begin
          if (done) begin
            phase_n = PG_IDLE;
          end else begin
            phase_n = PG_LO;
            tmr_n   = TMR_W'(PULSE_LO - 1);
          end
        end else begin
          tmr_n = tmr - TMR_W'(1);
        end
      end
      default: phase_n = PG_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_bar) begin
      phase   <= PG_IDLE;
      tmr     <= '0;
      rem     <= '0;
      dn_q    <= 1'b0;
      abort_q <= 1'b0;
      up      <= 1'b1;
      down    <= 1'b1;
    end else begin
      phase <= phase_n;
      tmr   <= tmr_n;
      rem   <= rem_n;
      dn_q  <= dn_n;
      // abort is latched so a one-cycle request in the low phase still ends the run
      if (phase == PG_IDLE) abort_q <= 1'b0;
      else                  abort_q <= abort_q | abort;
      up   <= !((phase_n == PG_LO) && !dn_n);
      down <= !((phase_n == PG_LO) && dn_n);
    end
  end

endmodule

// File: rtl/ls193_cmd_sequencer.sv
// Purpose: expands clear/load/up/down commands into timed LS193 pin activity and checks the count.
// Latency: pins move the cycle after acceptance; DONE pulses one cycle after settling.
// Backpressure: CMD_READY is high only in IDLE; commands offered while busy are dropped.
module ls193_cmd_sequencer
  import ls193_pkg::*;
#(
  parameter int PULSE_LO = 2,
  parameter int PULSE_HI = 2,
  parameter int CTRL_W   = 2,
  parameter int SETTLE   = 1,
  parameter int N_W      = 16
) (
  input  logic           CLK,
  input  logic           RST_Bar,
  input  logic           CMD_VALID,
  output logic           CMD_READY,
  input  logic [1:0]     CMD_OP,
  input  logic [N_W-1:0] CMD_ARG,
  input  logic           ABORT,
  output logic           CLR,
  output logic           LOAD_Bar,
  output logic [Q_W-1:0] DATA,
  output logic           UP,
  output logic           DOWN,
  input  logic [Q_W-1:0] Q_IN,
  input  logic           CO_Bar_IN,
  input  logic           BO_Bar_IN,
  output logic [Q_W-1:0] SHADOW,
  output logic           DONE,
  output logic           MISMATCH,
  output logic [7:0]     CARRY_CNT,
  output logic [7:0]     BORROW_CNT
);

  state_e           state, state_n;
  logic [TMR_W-1:0] tmr, tmr_n;
  logic             accept, pg_start, pg_rise, pg_sample, pg_done;
  logic             settle_go, dir_down;
  logic             clr_d, ldb_d, rdy_d, done_d;

  assign accept    = CMD_VALID && CMD_READY;
  assign pg_start  = accept && CMD_OP[1] && (CMD_ARG != '0);
  assign settle_go = (((state == ST_CLR_ASSERT) || (state == ST_LOAD_ASSERT)) && (tmr == '0))
                   || ((state == ST_PULSE) && pg_done);

  ls193_pulse_gen #(
    .PULSE_LO (PULSE_LO),
    .PULSE_HI (PULSE_HI),
    .N_W      (N_W)
  ) u_pulse_gen (
    .clk      (CLK),
    .rst_bar  (RST_Bar),
    .start    (pg_start),
    .dir_down (CMD_OP == OP_DOWN),
    .n        (CMD_ARG),
    .abort    (ABORT),
    .up       (UP),
    .down     (DOWN),
    .rise     (pg_rise),
    .sample   (pg_sample),
    .done     (pg_done)
  );

  always_ff @(posedge CLK) begin
    if (!RST_Bar) begin
      state     <= ST_IDLE;
      tmr       <= '0;
      CLR       <= 1'b0;
      LOAD_Bar  <= 1'b1;
      CMD_READY <= 1'b1;
      DONE      <= 1'b0;
    end else begin
      state     <= state_n;
      tmr       <= tmr_n;
      CLR       <= clr_d;
      LOAD_Bar  <= ldb_d;
      CMD_READY <= rdy_d;
      DONE      <= done_d;
    end
  end

  always_comb begin
    state_n = state;
    tmr_n   = tmr;
    if (settle_go) begin
      state_n = (SETTLE == 0) ? ST_CHECK : ST_SETTLE;
      tmr_n   = TMR_W'(SETTLE - 1);
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            case (CMD_OP)
              OP_CLEAR: begin
                state_n = ST_CLR_ASSERT;
                tmr_n   = TMR_W'(CTRL_W - 1);
              end
              // one extra cycle gives DATA setup before LOAD_Bar falls
              OP_LOAD: begin
                state_n = ST_LOAD_ASSERT;
                tmr_n   = TMR_W'(CTRL_W);
              end
              default: state_n = (CMD_ARG == '0) ? ST_CHECK : ST_PULSE;
            endcase
          end
        end
        ST_CLR_ASSERT, ST_LOAD_ASSERT: tmr_n = tmr - TMR_W'(1);
        ST_SETTLE: begin
          if (tmr == '0) state_n = ST_CHECK;
          else           tmr_n   = tmr - TMR_W'(1);
        end
        ST_CHECK: state_n = ST_IDLE;
        ST_PULSE: state_n = ST_PULSE;
        default:  state_n = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    clr_d  = (state_n == ST_CLR_ASSERT);
    ldb_d  = !((state_n == ST_LOAD_ASSERT) && (tmr_n != TMR_W'(CTRL_W)));
    rdy_d  = (state_n == ST_IDLE);
    done_d = (state_n == ST_CHECK);
  end

  always_ff @(posedge CLK) begin
    if (!RST_Bar) begin
      DATA       <= '0;
      SHADOW     <= '0;
      MISMATCH   <= 1'b0;
      CARRY_CNT  <= '0;
      BORROW_CNT <= '0;
      dir_down   <= 1'b0;
    end else begin
      if (accept) dir_down <= (CMD_OP == OP_DOWN);
      if (accept && (CMD_OP == OP_LOAD)) DATA <= CMD_ARG[Q_W-1:0];
      if (accept && (CMD_OP == OP_CLEAR))
        SHADOW <= '0;
      else if ((state == ST_LOAD_ASSERT) && (tmr == TMR_W'(CTRL_W)))
        SHADOW <= DATA;
      else if (pg_rise)
        SHADOW <= dir_down ? SHADOW - Q_W'(1) : SHADOW + Q_W'(1);
      if (pg_sample && !dir_down && !CO_Bar_IN && (CARRY_CNT != 8'hFF))
        CARRY_CNT <= CARRY_CNT + 8'd1;
      if (pg_sample && dir_down && !BO_Bar_IN && (BORROW_CNT != 8'hFF))
        BORROW_CNT <= BORROW_CNT + 8'd1;
      if ((state == ST_CHECK) && (Q_IN != SHADOW)) MISMATCH <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ls193_cmd_sequencer.sv
// Directed bench: LS193 behavioural model on the pins, pin-activity monitor, immediate-assert checks.
module tb_ls193_cmd_sequencer;

  localparam logic [1:0] C_CLEAR = 2'b00;
  localparam logic [1:0] C_LOAD  = 2'b01;
  localparam logic [1:0] C_UP    = 2'b10;
  localparam logic [1:0] C_DOWN  = 2'b11;

  logic        CLK = 1'b0;
  logic        RST_Bar, CMD_VALID, CMD_READY, ABORT;
  logic [1:0]  CMD_OP;
  logic [15:0] CMD_ARG;
  logic        CLR, LOAD_Bar, UP, DOWN, DONE, MISMATCH;
  logic [3:0]  DATA, Q_IN, SHADOW;
  logic        CO_Bar_IN, BO_Bar_IN;
  logic [7:0]  CARRY_CNT, BORROW_CNT;

  int checks = 0;
  int errors = 0;
  int d0, c0, l0, u0, n0, ul0;

  always #5 CLK = ~CLK;

  ls193_cmd_sequencer #(
    .PULSE_LO(2), .PULSE_HI(2), .CTRL_W(2), .SETTLE(1), .N_W(16)
  ) dut (
    .CLK(CLK), .RST_Bar(RST_Bar), .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY),
    .CMD_OP(CMD_OP), .CMD_ARG(CMD_ARG), .ABORT(ABORT), .CLR(CLR), .LOAD_Bar(LOAD_Bar),
    .DATA(DATA), .UP(UP), .DOWN(DOWN), .Q_IN(Q_IN), .CO_Bar_IN(CO_Bar_IN),
    .BO_Bar_IN(BO_Bar_IN), .SHADOW(SHADOW), .DONE(DONE), .MISMATCH(MISMATCH),
    .CARRY_CNT(CARRY_CNT), .BORROW_CNT(BORROW_CNT)
  );

  // LS193 model: level-sensitive clear/load, count on rising UP/DOWN
  logic [3:0] mq = 4'h7;
  logic       mup_q = 1'b1, mdn_q = 1'b1, tie0 = 1'b0;
  always @(negedge CLK) begin
    if (CLR)               mq = 4'h0;
    else if (!LOAD_Bar)    mq = DATA;
    else if (UP && !mup_q) mq = mq + 4'h1;
    else if (DOWN && !mdn_q) mq = mq - 4'h1;
    mup_q = UP;
    mdn_q = DOWN;
  end
  assign Q_IN      = tie0 ? 4'h0 : mq;
  assign CO_Bar_IN = !(!UP && (mq == 4'hF));
  assign BO_Bar_IN = !(!DOWN && (mq == 4'h0));

  int clr_hi = 0, ldb_lo = 0, up_rise = 0, dn_rise = 0, up_lo = 0, both_low = 0, done_cnt = 0;
  logic [3:0] data_prev = 4'h0, data_at_ld = 4'h0;
  logic ldb_prev = 1'b1, up_prev = 1'b1, dn_prev = 1'b1;
  always @(negedge CLK) begin
    if (CLR) clr_hi++;
    if (!LOAD_Bar) ldb_lo++;
    if (!LOAD_Bar && ldb_prev) data_at_ld = data_prev;
    if (UP && !up_prev) up_rise++;
    if (DOWN && !dn_prev) dn_rise++;
    if (!UP) up_lo++;
    if (!UP && !DOWN) both_low++;
    if (DONE) done_cnt++;
    ldb_prev  = LOAD_Bar;
    up_prev   = UP;
    dn_prev   = DOWN;
    data_prev = DATA;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [1:0] op, input logic [15:0] arg);
    int i = 0;
    while (!CMD_READY && i < 200) begin @(posedge CLK); #2; i++; end
    CMD_VALID = 1'b1; CMD_OP = op; CMD_ARG = arg;
    @(posedge CLK); #2;
    CMD_VALID = 1'b0;
    d0 = done_cnt;
  endtask

  task automatic wait_done();
    int i = 0;
    while (done_cnt == d0 && i < 300) begin @(posedge CLK); #2; i++; end
    chk("done_pulse", 32'(done_cnt - d0), 32'd1);
  endtask

  initial begin
    RST_Bar = 1'b0; CMD_VALID = 1'b0; CMD_OP = 2'b00; CMD_ARG = 16'h0; ABORT = 1'b0;
    repeat (3) @(posedge CLK);
    #2;
    chk("rst_clr",      32'(CLR), 32'd0);
    chk("rst_load_bar", 32'(LOAD_Bar), 32'd1);
    chk("rst_up_down",  32'({UP, DOWN}), 32'b11);
    chk("rst_data",     32'(DATA), 32'd0);
    chk("rst_shadow",   32'(SHADOW), 32'd0);
    chk("rst_flags",    32'({DONE, MISMATCH}), 32'd0);
    chk("rst_counts",   32'({CARRY_CNT, BORROW_CNT}), 32'd0);
    chk("rst_ready",    32'(CMD_READY), 32'd1);
    RST_Bar = 1'b1;
    @(posedge CLK); #2;

    // CLEAR
    c0 = clr_hi;
    send(C_CLEAR, 16'h0);
    chk("ready_low_busy", 32'(CMD_READY), 32'd0);
    wait_done();
    chk("clr_width",    32'(clr_hi - c0), 32'd2);
    chk("clear_shadow", 32'(SHADOW), 32'd0);
    chk("clear_mism",   32'(MISMATCH), 32'd0);
    chk("ready_after",  32'(CMD_READY), 32'd1);
    chk("done_one_cyc", 32'(DONE), 32'd0);

    // LOAD 13
    l0 = ldb_lo;
    send(C_LOAD, 16'h00AD);
    wait_done();
    chk("load_setup_data", 32'(data_at_ld), 32'hD);
    chk("load_width",      32'(ldb_lo - l0), 32'd2);
    chk("load_data_held",  32'(DATA), 32'hD);
    chk("load_shadow",     32'(SHADOW), 32'hD);
    chk("load_q",          32'(Q_IN), 32'hD);
    chk("load_mism",       32'(MISMATCH), 32'd0);

    // LOAD 14, UP 3: wraps through 15 -> 0 -> 1, one carry
    send(C_LOAD, 16'h000E);
    wait_done();
    u0 = up_rise; n0 = dn_rise; ul0 = up_lo;
    send(C_UP, 16'd3);
    wait_done();
    chk("up3_rises",   32'(up_rise - u0), 32'd3);
    chk("up3_low_cyc", 32'(up_lo - ul0), 32'd6);
    chk("up3_no_down", 32'(dn_rise - n0), 32'd0);
    chk("up3_shadow",  32'(SHADOW), 32'h1);
    chk("up3_carry",   32'(CARRY_CNT), 32'd1);
    chk("up3_q",       32'(Q_IN), 32'h1);
    chk("up3_mism",    32'(MISMATCH), 32'd0);

    // LOAD 1, DOWN 2: 0 then 15, one borrow
    send(C_LOAD, 16'h0001);
    wait_done();
    u0 = up_rise; n0 = dn_rise;
    send(C_DOWN, 16'd2);
    wait_done();
    chk("dn2_rises",   32'(dn_rise - n0), 32'd2);
    chk("dn2_no_up",   32'(up_rise - u0), 32'd0);
    chk("dn2_shadow",  32'(SHADOW), 32'hF);
    chk("dn2_borrow",  32'(BORROW_CNT), 32'd1);
    chk("dn2_carry",   32'(CARRY_CNT), 32'd1);
    chk("dn2_mism",    32'(MISMATCH), 32'd0);

    // UP 10 from 15, abort in pulse 3; a CLEAR offered while busy must be dropped
    u0 = up_rise; c0 = clr_hi;
    send(C_UP, 16'd10);
    begin
      int i = 0;
      while (!((up_rise - u0) == 2 && !UP) && i < 200) begin @(posedge CLK); #2; i++; end
      chk("abort_reached_p3", 32'(i < 200), 32'd1);
    end
    ABORT = 1'b1; CMD_VALID = 1'b1; CMD_OP = C_CLEAR; CMD_ARG = 16'h0;
    @(posedge CLK); #2;
    ABORT = 1'b0; CMD_VALID = 1'b0;
    wait_done();
    chk("abort_rises",  32'(up_rise - u0), 32'd3);
    chk("abort_shadow", 32'(SHADOW), 32'h2);
    chk("busy_ignored", 32'(clr_hi - c0), 32'd0);
    chk("abort_carry",  32'(CARRY_CNT), 32'd2);
    chk("abort_mism",   32'(MISMATCH), 32'd0);

    // UP with N=0: completes with no pin activity
    u0 = up_rise; ul0 = up_lo;
    send(C_UP, 16'd0);
    wait_done();
    chk("n0_no_pulse",  32'(up_lo - ul0), 32'd0);
    chk("n0_shadow",    32'(SHADOW), 32'h2);

    chk("never_both_low", 32'(both_low), 32'd0);

    // Q tied low: LOAD 5 mismatches; flag survives a CLEAR
    tie0 = 1'b1;
    send(C_LOAD, 16'h0005);
    wait_done();
    chk("tie_mism_set",  32'(MISMATCH), 32'd1);
    send(C_CLEAR, 16'h0);
    wait_done();
    chk("tie_mism_sticky", 32'(MISMATCH), 32'd1);
    tie0 = 1'b0;

    // Reset in the middle of an UP pulse
    send(C_UP, 16'd5);
    begin
      int i = 0;
      while (UP && i < 50) begin @(posedge CLK); #2; i++; end
      chk("up_went_low", 32'(UP), 32'd0);
    end
    RST_Bar = 1'b0;
    @(posedge CLK); #2;
    chk("rst_mid_up",    32'(UP), 32'd1);
    chk("rst_mid_ready", 32'(CMD_READY), 32'd1);
    chk("rst_mid_mism",  32'(MISMATCH), 32'd0);
    RST_Bar = 1'b1;
    d0 = done_cnt;
    repeat (20) @(posedge CLK);
    #2;
    chk("rst_no_done", 32'(done_cnt - d0), 32'd0);
    chk("rst_idle_up", 32'(UP), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ls193_cmd_sequencer.md
Name: ls193_cmd_sequencer

Overview:
- Synchronous command sequencer that drives the asynchronous control pins of one LS193 4-bit up/down counter: CLR, LOAD_Bar, A–D, UP and DOWN.
- Accepts clear/load/count-up/count-down commands over a valid/ready handshake and expands each into correctly timed pin pulses.
- Keeps a shadow copy of the expected count, checks the counter outputs against it, and counts carry/borrow events.
- Sits between test/firmware logic and the counter model or the physical SN74LS193N.

Parameters:
- PULSE_LO, default 2: cycles the UP/DOWN line is held low per count pulse (min 1).
- PULSE_HI, default 2: cycles the line is held high after the rising edge (min 1).
- CTRL_W, default 2: cycles CLR is held high or LOAD_Bar is held low (min 1).
- SETTLE, default 1: cycles to wait after the last edge before comparing Q (min 0).
- N_W, default 16: width of the count-repeat argument.

Ports:
- CLK  in  1  system clock, rising edge.
- RST_Bar  in  1  synchronous, active-low reset.
- CMD_VALID  in  1  command present.
- CMD_READY  out  1  sequencer can accept a command; high only in IDLE.
- CMD_OP  in  2  command code: 00 CLEAR, 01 LOAD, 10 UP, 11 DOWN.
- CMD_ARG  in  N_W  LOAD: bits[3:0] are the preset value. UP/DOWN: number of pulses N. Ignored for CLEAR.
- ABORT  in  1  stop counting after the current pulse completes.
- CLR  out  1  to counter CLR, active high.
- LOAD_Bar  out  1  to counter LOAD_Bar, active low.
- DATA  out  4  to counter D,C,B,A; DATA[0] drives A.
- UP  out  1  to counter UP.
- DOWN  out  1  to counter DOWN.
- Q_IN  in  4  counter outputs QD..QA, assumed already synchronized.
- CO_Bar_IN  in  1  counter carry output, active low.
- BO_Bar_IN  in  1  counter borrow output, active low.
- SHADOW  out  4  expected counter value.
- DONE  out  1  one-cycle pulse at command completion.
- MISMATCH  out  1  sticky flag: Q_IN differed from SHADOW at a check.
- CARRY_CNT  out  8  number of CO_Bar low samples observed; saturates at 255.
- BORROW_CNT  out  8  number of BO_Bar low samples observed; saturates at 255.

Behaviour:
- Reset, applied at the clock edge while RST_Bar is low, from any state:
  - Outputs: CLR=0, LOAD_Bar=1, UP=1, DOWN=1, DATA=0, SHADOW=0, DONE=0, MISMATCH=0, CARRY_CNT=0, BORROW_CNT=0, CMD_READY=1.
  - State returns to IDLE. A pulse cut off mid-operation is simply released high; no completion is reported.
- State machine:
  - IDLE -> CLR_ASSERT, LOAD_ASSERT or PULSE_LO.
  - CLR_ASSERT and LOAD_ASSERT -> SETTLE.
  - PULSE_LO -> PULSE_HI -> PULSE_LO or SETTLE.
  - SETTLE -> CHECK -> IDLE.
- Handshake:
  - A command is accepted on the cycle where CMD_VALID and CMD_READY are both high.
  - CMD_READY goes low the next cycle and stays low until the cycle after DONE.
  - CMD_VALID while busy is ignored, not queued.
- CLEAR:
  - CLR is high for exactly CTRL_W cycles, starting the cycle after acceptance.
  - SHADOW becomes 0 when CLR rises.
- LOAD:
  - DATA is set to CMD_ARG[3:0] at acceptance and held through the whole command.
  - LOAD_Bar is low for CTRL_W cycles, starting one cycle after DATA changes (setup cycle).
  - SHADOW becomes CMD_ARG[3:0] when LOAD_Bar falls.
- UP/DOWN with N>0:
  - Only the selected line toggles; the other stays 1.
  - Each pulse is PULSE_LO low cycles followed by PULSE_HI high cycles.
  - SHADOW updates by ±1 mod 16 in the cycle the line rises: 15 wraps to 0 on UP, 0 wraps to 15 on DOWN.
  - A remaining-pulse counter decrements on each rising edge; after the last high phase, go to SETTLE.
- UP/DOWN with N=0: go straight to CHECK; no pin activity.
- Carry/borrow sampling:
  - Sampled in the last low cycle of each pulse: CO_Bar_IN during UP pulses, BO_Bar_IN during DOWN pulses.
  - A low sample increments CARRY_CNT or BORROW_CNT respectively.
  - Expected behaviour: a low sample occurs exactly when SHADOW==15 (UP) or SHADOW==0 (DOWN) before the edge.
- ABORT:
  - Sampled in PULSE_LO and PULSE_HI.
  - The current pulse always completes its high phase, then the FSM goes to SETTLE.
  - Remaining pulses are discarded.
  - ABORT in other states has no effect.
- SETTLE: waits SETTLE cycles; 0 means pass through in zero cycles.
- CHECK (one cycle):
  - If Q_IN != SHADOW, set MISMATCH.
  - Assert DONE.
  - MISMATCH is cleared only by reset.
- Invariants:
  - CLR, LOAD_Bar low, and UP/DOWN low are mutually exclusive.
  - UP and DOWN are never low simultaneously.
  - All outputs are registered.

Decomposition:
- Shared package ls193_pkg:
  - Opcode constants OP_CLEAR, OP_LOAD, OP_UP, OP_DOWN.
  - FSM state encoding.
  - Width constant Q_W=4.
- One natural sub-module, ls193_pulse_gen:
  - Inputs: start, dir, N, abort.
  - Produces the UP/DOWN waveform, rise strobes, sample strobes and a done signal.
- The command FSM, shadow register and counters stay in the top level.

Test Plan:
- Reset, then CLEAR -> CLR high exactly 2 cycles; DONE pulse; SHADOW=0; MISMATCH=0 when connected to the LS193 model.
- LOAD with ARG=4'hD -> DATA=1101 one cycle before LOAD_Bar is low for 2 cycles; Q_IN=13; SHADOW=13; DONE pulse.
- LOAD 14, then UP with N=3 -> 3 UP pulses, each 2 cycles low and 2 high; SHADOW goes 15, 0, 1; CARRY_CNT=1; Q_IN=1; MISMATCH=0.
- LOAD 1, then DOWN with N=2 -> SHADOW goes 0, 15; BORROW_CNT=1; DOWN is never low together with UP.
- UP with N=10 and ABORT asserted during pulse 3 -> exactly 3 rising edges; DONE pulse; SHADOW = start+3; CMD_VALID during the run is ignored.
- Tie Q_IN to 4'h0 and LOAD 5 -> MISMATCH=1 and stays set through a following CLEAR; RST_Bar low mid-UP-pulse -> UP=1 and state IDLE at the next edge.
